// File: rtl/alu_vec_checker.sv
// Self-checking am2901 vector engine: preloads Q, executes each vector, compares {flags,Y} against a reference ROM.
// Latency: 3+SETTLE cycles per vector, done one cycle after the final COMMIT; start is ignored while busy.
// Optional ALU_CHK_MISR_EN adds a 16-bit signature output (sig) folded once per vector.
module alu_vec_checker #(
    parameter int DW     = 4,
    parameter int AW     = 12,
    parameter int SETTLE = 2,
    parameter int RW     = DW + 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop_on_fail,
    input  logic [AW-1:0]     last_addr,
    output logic [AW-1:0]     vec_addr,
    input  logic [2*DW+3:0]   vec_data,
    input  logic [RW-1:0]     ref_data,
    output logic [8:0]        alu_i,
    output logic [DW-1:0]     alu_d,
    output logic              alu_cin,
    output logic              alu_ce,
    input  logic [DW-1:0]     alu_y,
    input  logic [5:0]        alu_flags,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW-1:0]     fail_addr,
    output logic [RW-1:0]     fail_xor,
    output logic [15:0]       err_cnt
`ifdef ALU_CHK_MISR_EN
    ,
    output logic [15:0]       sig
`endif
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOADQ,
        S_EXEC,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic            r_sop;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_dd;
    logic [RW-1:0]   r_ref;
    logic            r_mis;
    logic [8:0]      r_alu_i;
    logic            r_alu_cin;
    logic            r_alu_ce;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [AW-1:0]   r_fail_addr;
    logic [RW-1:0]   r_fail_xor;
    logic [15:0]     r_err;

    logic [2:0]      w_func;
    logic            w_cin;
    logic [DW-1:0]   w_dq;
    logic [DW-1:0]   w_dd;
    logic [RW-1:0]   w_obs;
    logic            w_mis;

    assign w_func = vec_data[2*DW+3:2*DW+1];
    assign w_cin  = vec_data[2*DW];
    assign w_dq   = vec_data[2*DW-1:DW];
    assign w_dd   = vec_data[DW-1:0];
    assign w_obs  = {alu_flags, alu_y};
    assign w_mis  = (w_obs != r_ref);

`ifdef ALU_CHK_MISR_EN
    localparam int OW = (RW < 16) ? RW : 16;
    logic [RW-1:0]   r_obs;
    logic [15:0]     r_misr;
    logic [15:0]     w_obs16;
    logic [15:0]     w_misr_next;

    assign w_obs16     = 16'(r_obs[OW-1:0]);
    // x^16+x^12+x^5+1: shift out the top bit and feed it back as 0x1021
    assign w_misr_next = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000) ^ w_obs16;
    assign sig         = r_misr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_sop       <= 1'b0;
            r_cnt       <= '0;
            r_dd        <= '0;
            r_ref       <= '0;
            r_mis       <= 1'b0;
            r_alu_i     <= '0;
            r_alu_cin   <= 1'b0;
            r_alu_ce    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_xor  <= '0;
            r_err       <= '0;
`ifdef ALU_CHK_MISR_EN
            r_obs       <= '0;
            r_misr      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr      <= '0;
                        r_err       <= '0;
                        r_fail_addr <= '0;
                        r_fail_xor  <= '0;
                        r_sop       <= stop_on_fail;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
`ifdef ALU_CHK_MISR_EN
                        r_misr      <= 16'hFFFF;
`endif
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Q load: source D,0; ADD; destination QREG
                    r_alu_i   <= 9'h007;
                    r_alu_cin <= 1'b0;
                    r_alu_ce  <= 1'b1;
                    r_state   <= S_LOADQ;
                end
                S_LOADQ: begin
                    r_alu_i   <= {3'b000, w_func, 3'b110};
                    r_alu_cin <= w_cin;
                    r_alu_ce  <= 1'b0;
                    r_dd      <= w_dd;
                    r_ref     <= ref_data;
                    r_cnt     <= '0;
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_cnt == CW'(SETTLE - 1)) begin
                        r_mis <= w_mis;
`ifdef ALU_CHK_MISR_EN
                        r_obs <= w_obs;
`endif
                        if (w_mis) begin
                            if (r_err != '1) r_err <= r_err + 16'd1;
                            if (r_err == '0) begin
                                r_fail_addr <= r_addr;
                                r_fail_xor  <= w_obs ^ r_ref;
                            end
                        end
                        r_alu_ce <= 1'b1;
                        r_state  <= S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_alu_ce <= 1'b0;
`ifdef ALU_CHK_MISR_EN
                    r_misr   <= w_misr_next;
`endif
                    if ((r_mis && r_sop) || (r_addr == last_addr)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Q preload needs dq in the same cycle the ROM presents it
    assign alu_d     = (r_state == S_LOADQ) ? w_dq : r_dd;
    assign vec_addr  = r_addr;
    assign alu_i     = r_alu_i;
    assign alu_cin   = r_alu_cin;
    assign alu_ce    = r_alu_ce;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_addr = r_fail_addr;
    assign fail_xor  = r_fail_xor;
    assign err_cnt   = r_err;

endmodule

// File: doc/alu_vec_checker.md
Name: alu_vec_checker

Overview:
- Synthesizable self-checking vector engine for the am2901 ALU slice chain; the parametrised, on-chip successor to the simulation-only vector bench.
- Walks a vector ROM, preloads Q, executes each function and compares Y plus flags against a reference ROM.
- Records first failure, counts errors and reports pass/fail.
- Targets the DE0 board and runs at full clock using an ALU clock enable rather than a toggled clock.

Parameters:
- DW, 4, ALU data width in bits (4 per slice; 4/8/12/16).
- AW, 12, vector address width.
- SETTLE, 2, cycles the EXEC operands are held before the compare (>=1).
- RW, DW+6, reference/observed word width (derived, not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- stop_on_fail  in  1  sampled at start; 1 = halt at first mismatch.
- last_addr  in  AW  last vector address, inclusive.
- vec_addr  out  AW  ROM address; both ROMs are synchronous with 1-cycle latency.
- vec_data  in  2*DW+4  {func[2:0], cin, dq[DW-1:0], dd[DW-1:0]}.
- ref_data  in  RW  expected {g_n, p_n, cout, ovr, f3, zf, y[DW-1:0]}.
- alu_i  out  9  am2901 I[8:0].
- alu_d  out  DW  ALU D port.
- alu_cin  out  1  ALU carry in.
- alu_ce  out  1  ALU register clock enable.
- alu_y  in  DW  ALU Y output.
- alu_flags  in  6  {g_n, p_n, cout, ovr, f3, zf}.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  done and err_cnt==0.
- fail_addr  out  AW  address of the first mismatch.
- fail_xor  out  RW  observed XOR reference at the first mismatch.
- err_cnt  out  16  mismatch count; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All outputs are 0, including alu_i, alu_d, alu_cin and alu_ce.
- Observed word: obs = {alu_flags, alu_y}.
- FSM states: IDLE, FETCH, LOADQ, EXEC, COMMIT, DONE.
- IDLE/DONE, start=1:
  - addr=0; err_cnt, fail_addr, fail_xor and the MISR cleared.
  - stop_on_fail latched; busy=1; done=0; next state FETCH.
- FETCH (1 cycle): vec_addr=addr is presented; ROM data is valid in the next cycle.
- LOADQ (1 cycle):
  - vec_data and ref_data are registered.
  - alu_i=9'h007 (source D,0; ADD; dest QREG), alu_d=dq, alu_cin=0, alu_ce=1. Q loads dq at the cycle end.
- EXEC (SETTLE cycles):
  - alu_i={3'b000, func, 3'b110} (source D,Q), alu_d=dd, alu_cin=cin, alu_ce=0.
  - On the last EXEC cycle obs is registered and compared with ref.
  - On mismatch: err_cnt increments (saturating). On the first mismatch only, fail_addr and fail_xor are captured.
- COMMIT (1 cycle): EXEC drive values held with alu_ce=1, matching the am2901 register clock edge after compare.
  - Stop if (mismatch && stop_on_fail) or addr==last_addr: go to DONE.
  - Otherwise addr+1 and go to FETCH.
- Throughput: 3+SETTLE cycles per vector (5 at default). done asserts on the cycle after the final COMMIT.
- DONE: busy=0, done=1, pass=(err_cnt==0). Results are held until start or rst.
- Boundaries:
  - last_addr=0 runs exactly one vector.
  - last_addr=all-ones terminates without address wrap.
  - start while busy is ignored.
  - rst mid-run abandons the run; a following start restarts at address 0.
- Width rule: DW>4 drives an DW-bit chain. Flags are the chain-level flags supplied by the instantiating logic; the block does not interpret carry lookahead.

Optional Feature:
- Macro: ALU_CHK_MISR_EN.
- Defined:
  - Adds output sig[15:0].
  - A 16-bit MISR (polynomial x^16+x^12+x^5+1, seed 16'hFFFF at start) folds the zero-extended/truncated obs[15:0] once per vector, in COMMIT.
  - sig is held in DONE.
- Undefined: sig is absent and no MISR logic is generated.

Test Plan:
- All-match: behavioural ALU, consistent ROMs, last_addr=15, stop_on_fail=0 -> done 80 cycles after start, pass=1, err_cnt=0, busy low.
- Stop on fail: ref[7] cout bit flipped, stop_on_fail=1 -> halts after vector 7, fail_addr=7, fail_xor=10'h080, err_cnt=1, pass=0.
- Continue on fail: refs 3 and 9 corrupted, stop_on_fail=0, last_addr=15 -> err_cnt=2, fail_addr=3, run completes all 16 vectors.
- Reset mid-run: rst pulsed during vector 5 -> all outputs 0 immediately; subsequent start runs from vec_addr=0 to completion.
- Single vector and busy-start: last_addr=0 -> one vector, done after 5 cycles; a start pulse while busy has no effect.
- MISR (ALU_CHK_MISR_EN): 16-vector run -> sig equals the bench model signature; a single-bit ALU fault injected -> sig differs.
